// File: rtl/fir_mac_seq.sv
// fir_mac_seq: tap sequencer that drives fir_alu through one FIR output per sample.
// Accepts a Q15 sample into a circular history, clears the ALU, issues NTAPS MACs
// (h[k] x x[n-k]), captures the Q7.9 result and offers it on a valid/ready port.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     sample handshake, in_sample = signed Q15 sample
//   coef_addr/coef_data   sync coefficient ROM (1-cycle read latency)
//   clr_acc/en_mac        fir_alu accumulator clear / multiply-accumulate strobe
//   a_q15/b_q15           fir_alu operands (coefficient, history sample)
//   y_q7_9/y_saturated    fir_alu rounded/saturated result and flag
//   out_valid/out_ready   result handshake, out_data = Q7.9, out_sat = saturated
module fir_mac_seq #(
    parameter int NTAPS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_sample,
    output logic [AW-1:0] coef_addr,
    input  logic [15:0]   coef_data,
    output logic          clr_acc,
    output logic          en_mac,
    output logic [15:0]   a_q15,
    output logic [15:0]   b_q15,
    input  logic [15:0]   y_q7_9,
    input  logic          y_saturated,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_CAPT,
        S_OUT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_hist [NTAPS];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_k;
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_sat;

    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_rd_idx;
    logic          w_last_tap;

    // Explicit wrap so NTAPS need not be a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == AW'(NTAPS - 1)) ? '0
                                                       : r_wr_ptr + AW'(1);
    assign w_last_tap   = (r_k == AW'(NTAPS - 1));

    // History index (cur - k) mod NTAPS; k=0 is the newest sample.
    always_comb begin
        if (r_cur >= r_k) begin
            w_rd_idx = r_cur - r_k;
        end else begin
            w_rd_idx = AW'(32'(r_cur) + NTAPS - 32'(r_k));
        end
    end

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and ALU-facing outputs
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        coef_addr   = '0;
        clr_acc     = 1'b0;
        en_mac      = 1'b0;
        a_q15       = '0;
        b_q15       = '0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // coef_addr=0 here so h[0] is on coef_data for tap 0.
                clr_acc     = 1'b1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                en_mac    = 1'b1;
                a_q15     = coef_data;
                b_q15     = r_hist[w_rd_idx];
                // Prefetch the next tap's coefficient; wraps harmlessly on the last tap.
                coef_addr = r_k + AW'(1);
                if (w_last_tap) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // History, tap counter and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_cur       <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_hist[r_wr_ptr] <= in_sample;
                        r_cur            <= r_wr_ptr;
                        r_wr_ptr         <= w_wr_ptr_nxt;
                    end
                end
                S_CLEAR: begin
                    r_k <= '0;
                end
                S_MAC: begin
                    if (!w_last_tap) begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_CAPT: begin
                    // ALU result reflects the last MAC edge by now.
                    r_out_data  <= y_q7_9;
                    r_out_sat   <= y_saturated;
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: bench for fir_mac_seq with a behavioural fir_alu and sync ROM.
// Results are checked against a scoreboard of expected outputs.
module tb_fir_mac_seq;

    localparam int NT = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_sample = '0;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_data = '0;
    logic          clr_acc;
    logic          en_mac;
    logic [15:0]   a_q15;
    logic [15:0]   b_q15;
    logic [15:0]   y_q7_9;
    logic          y_saturated;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_data;
    logic          out_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fir_mac_seq #(.NTAPS(NT), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .clr_acc(clr_acc), .en_mac(en_mac), .a_q15(a_q15), .b_q15(b_q15),
        .y_q7_9(y_q7_9), .y_saturated(y_saturated),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    // Coefficient ROM, one-cycle read latency.
    logic [15:0] rom [NT];
    always @(posedge clk) coef_data <= rom[coef_addr];

    // Behavioural fir_alu: Q30 accumulate, round to Q7.9, saturate.
    longint acc;
    longint y_full;
    always @(posedge clk) begin
        if (rst || clr_acc) acc <= 0;
        else if (en_mac) acc <= acc + longint'($signed(a_q15)) * longint'($signed(b_q15));
    end
    always_comb begin
        y_full = (acc + longint'(1 << 20)) >>> 21;
        if (y_full > 32767) begin
            y_q7_9 = 16'h7fff; y_saturated = 1'b1;
        end else if (y_full < -32768) begin
            y_q7_9 = 16'h8000; y_saturated = 1'b1;
        end else begin
            y_q7_9 = y_full[15:0]; y_saturated = 1'b0;
        end
    end

    // Scoreboard consumer: compares each accepted output with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got data=%0d sat=%0d, none expected",
                         $signed(out_data), out_sat);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.d || out_sat !== e.s) begin
                    errors++;
                    $display("FAIL sb_result: got data=%0d sat=%0d expected data=%0d sat=%0d",
                             $signed(out_data), out_sat, $signed(e.d), e.s);
                end
            end
        end
    end

    task automatic load_rom(input int mode);
        for (int k = 0; k < NT; k++) begin
            case (mode)
                0: rom[k] = 16'd16384;
                1: rom[k] = 16'(k * 256);
                default: rom[k] = 16'h8000;
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    // Push expectation, wait for in_ready, present the sample for one edge.
    task automatic feed(input logic [15:0] x, input logic [15:0] ed, input logic es);
        int t = 0;
        exp_t e;
        e.d = ed; e.s = es;
        sb.push_back(e);
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk); t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL feed_timeout: in_ready=%0d expected 1", in_ready);
        end else begin
            in_valid = 1'b1; in_sample = x;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk); t++;
        end
        checks++;
        if (sb.size() != 0 || !in_ready) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 9;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0d expected 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
        if (out_data !== 16'd0) begin errors++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
        if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat: got %0d expected 0", out_sat); end
        if (clr_acc !== 1'b0) begin errors++; $display("FAIL rst_clr_acc: got %0d expected 0", clr_acc); end
        if (en_mac !== 1'b0) begin errors++; $display("FAIL rst_en_mac: got %0d expected 0", en_mac); end
        if (a_q15 !== 16'd0) begin errors++; $display("FAIL rst_a_q15: got %0d expected 0", a_q15); end
        if (b_q15 !== 16'd0) begin errors++; $display("FAIL rst_b_q15: got %0d expected 0", b_q15); end
        if (coef_addr !== '0) begin errors++; $display("FAIL rst_coef_addr: got %0d expected 0", coef_addr); end
        do_reset();
    endtask

    task automatic test_impulse();
        do_reset();
        load_rom(0);
        feed(16'd16384, 16'd128, 1'b0);
        for (int n = 1; n < NT; n++) feed(16'd0, 16'd128, 1'b0);
        drain();
    endtask

    task automatic test_ordering();
        do_reset();
        load_rom(1);
        for (int n = 0; n < NT; n++) begin
            int k = 0;
            int t = 0;
            feed((n == 0) ? 16'd16384 : 16'd0, 16'(2 * n), 1'b0);
            while (!out_valid && t < 100) begin
                @(negedge clk); t++;
                if (en_mac) begin
                    logic [15:0] eb;
                    eb = (k == n) ? 16'd16384 : 16'd0;
                    checks++;
                    if (a_q15 !== 16'(k * 256) || b_q15 !== eb) begin
                        errors++;
                        $display("FAIL order_pair n=%0d k=%0d: got a=%0d b=%0d expected a=%0d b=%0d",
                                 n, k, a_q15, b_q15, k * 256, eb);
                    end
                    k++;
                end
            end
            checks++;
            if (k != NT) begin
                errors++;
                $display("FAIL order_mac_count n=%0d: got %0d expected %0d", n, k, NT);
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        do_reset();
        load_rom(2);
        for (int n = 1; n <= NT; n++) begin
            if (n < NT) feed(16'h8000, 16'(512 * n), 1'b0);
            else feed(16'h8000, 16'd32767, 1'b1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int t = 0;
        do_reset();
        load_rom(0);
        out_ready = 1'b0;
        feed(16'd16384, 16'd128, 1'b0);
        while (!out_valid && t < 100) begin
            @(negedge clk); t++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd128 || in_ready !== 1'b0 || en_mac !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d: got v=%0d d=%0d ir=%0d en=%0d expected v=1 d=128 ir=0 en=0",
                         c, out_valid, out_data, in_ready, en_mac);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%0d ir=%0d expected v=0 ir=1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_latency();
        int t = 0;
        int clr_cnt = 0;
        int en_cnt = 0;
        int en_first = 0;
        int ov_first = 0;
        int ir_bad = 0;
        exp_t e;
        do_reset();
        load_rom(0);
        e.d = 16'd64; e.s = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk); t++;
        end
        in_valid = 1'b1; in_sample = 16'd8192;
        @(posedge clk);
        #1 in_sample = 16'd1000;
        for (int c = 1; c <= 67; c++) begin
            @(negedge clk);
            if (clr_acc) begin
                clr_cnt++;
                if (c != 1) ir_bad++;
            end
            if (en_mac) begin
                en_cnt++;
                if (en_first == 0) en_first = c;
            end
            if (out_valid && ov_first == 0) ov_first = c;
            if (in_ready) ir_bad++;
        end
        in_valid = 1'b0;
        checks += 4;
        if (clr_cnt != 1) begin errors++; $display("FAIL lat_clr: got %0d cycles expected 1", clr_cnt); end
        if (en_cnt != NT || en_first != 2) begin
            errors++; $display("FAIL lat_en: got %0d cycles from %0d expected %0d from 2", en_cnt, en_first, NT);
        end
        if (ov_first != 67) begin errors++; $display("FAIL lat_out_valid: got cycle %0d expected 67", ov_first); end
        if (ir_bad != 0) begin errors++; $display("FAIL lat_busy: got %0d violations expected 0", ir_bad); end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid || en_mac) ir_bad++;
        end
        checks++;
        if (ir_bad != 0) begin errors++; $display("FAIL lat_ignored: got %0d busy cycles expected 0", ir_bad); end
        // History must hold 8192 then 0; an accepted 1000 would change this.
        feed(16'd0, 16'd64, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int k = 0;
        do_reset();
        load_rom(0);
        feed(16'd16384, 16'd128, 1'b0);
        while (k < 30 && t < 100) begin
            @(negedge clk); t++;
            if (en_mac) k++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || en_mac !== 1'b0 || clr_acc !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got v=%0d ir=%0d en=%0d clr=%0d expected 0 1 0 0",
                     out_valid, in_ready, en_mac, clr_acc);
        end
        feed(16'd16384, 16'd128, 1'b0);
        drain();
    endtask

    initial begin
        load_rom(0);
        test_reset();
        test_impulse();
        test_ordering();
        test_saturation();
        test_backpressure();
        test_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
